square_unit_v2: RTL and testbench

- Next-generation per-square move-generation cell for the board array. Generalised over board coordinate width and move-buffer depth.
- Generates moves for either side to move; the existing cell is white-only.
- Adds correct slider blocking, king single-step, pawn promotion, en-passant and double-push rules.
- Holds moves in a multi-write internal FIFO with a valid/ready output and a sticky overflow flag.

---
 rtl/square_unit_v2.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_square_unit_v2.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_unit_v2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : square_unit_v2                                                |
// | Purpose  : Per-square move-generation cell for the board array. Emits    |
// |            the resident piece's tokens, evaluates tokens arriving from   |
// |            neighbours, forwards unblocked sliders and queues the         |
// |            resulting moves in a multi-write FIFO.                        |
// | Ports    : clk, reset        clock / synchronous active-high reset       |
// |            start             begin generation (accepted in IDLE/DONE)    |
// |            xpos, ypos        this square's coordinates                   |
// |            cpiece, side      {color,type} of occupant / colour to move   |
// |            ep_target         square is the en-passant target             |
// |            ray_in/ray_out    8 directional token lanes (registered out)  |
// |            knight_in/_out    8 knight token lanes (registered out)       |
// |            hold_in/hold_out  neighbourhood still has rays in flight      |
// |            move_data/valid/ready  move FIFO head, pop on valid&ready     |
// |            done, overflow    generation finished / sticky move drop      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module square_unit_v2 #(
    parameter int COORD_W    = 3,
    parameter int DEPTH      = 32,
    parameter int WDT_CYCLES = 15,
    localparam int TOK_W     = 2*COORD_W + 3,
    localparam int MV_W      = 7 + 4*COORD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [COORD_W-1:0]   xpos,
    input  logic [COORD_W-1:0]   ypos,
    input  logic [3:0]           cpiece,
    input  logic                 side,
    input  logic                 ep_target,
    input  logic [8*TOK_W-1:0]   ray_in,
    input  logic [8*TOK_W-1:0]   knight_in,
    input  logic                 hold_in,
    output logic [8*TOK_W-1:0]   ray_out,
    output logic [8*TOK_W-1:0]   knight_out,
    output logic                 hold_out,
    output logic [MV_W-1:0]      move_data,
    output logic                 move_valid,
    input  logic                 move_ready,
    output logic                 done,
    output logic                 overflow
);

    localparam int c_NCAND = 16;
    localparam int c_PW    = $clog2(DEPTH);
    localparam int c_CW    = $clog2(DEPTH + 1) + 1;
    localparam int c_WW    = $clog2(WDT_CYCLES + 1);

    localparam logic [c_CW-1:0]    c_DEPTH    = c_CW'(DEPTH);
    localparam logic [c_PW-1:0]    c_PTR_LAST = c_PW'(DEPTH - 1);
    localparam logic [c_WW-1:0]    c_WDT_LAST = c_WW'(WDT_CYCLES - 1);
    localparam logic [COORD_W-1:0] c_ROW_ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] c_ROW_LAST = {COORD_W{1'b1}};
    localparam logic [COORD_W-1:0] c_ROW_PRE  = c_ROW_LAST - c_ROW_ONE;
    localparam logic [COORD_W:0]   c_X1       = (COORD_W+1)'(1);
    localparam logic [COORD_W:0]   c_X2       = (COORD_W+1)'(2);

    localparam logic [2:0] c_EMPTY  = 3'd0;
    localparam logic [2:0] c_PAWN   = 3'd1;
    localparam logic [2:0] c_KNIGHT = 3'd2;
    localparam logic [2:0] c_BISHOP = 3'd3;
    localparam logic [2:0] c_ROOK   = 3'd4;
    localparam logic [2:0] c_QUEEN  = 3'd5;
    localparam logic [2:0] c_KING   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_PROP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [8*TOK_W-1:0]    r_ray_out;
    logic [8*TOK_W-1:0]    r_kn_out;
    logic                  r_overflow;
    logic                  r_prop_seen;   // current PROP cycle is not the first
    logic [c_WW-1:0]       r_wdt;
    logic [c_CW-1:0]       r_count;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_PW-1:0]       r_wr_ptr;
    logic [MV_W-1:0]       r_mem [DEPTH];

    logic                  w_start_acc;
    logic                  w_active;
    logic                  w_wdt_expire;
    logic                  w_ray_busy;
    logic                  w_prop_exit;
    logic                  w_sq_empty;
    logic                  w_opp;
    logic                  w_emit;
    logic [7:0]            w_ray_mask;
    logic                  w_kn_emit;
    logic [TOK_W-1:0]      w_own_tok;
    logic [COORD_W-1:0]    w_start_row;
    logic [COORD_W-1:0]    w_last_rank;
    logic [8*TOK_W-1:0]    w_fwd;
    logic [8*TOK_W-1:0]    w_ray_nxt;
    logic [MV_W-1:0]       w_cand [c_NCAND];
    logic [c_NCAND-1:0]    w_cand_vld;
    logic [c_CW-1:0]       w_slot [c_NCAND];
    logic [c_NCAND-1:0]    w_wr_en;
    logic [c_PW-1:0]       w_wr_idx [c_NCAND];
    logic [c_CW-1:0]       w_nvalid;
    logic [c_CW-1:0]       w_nwr;
    logic [c_CW-1:0]       w_free;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_hold;

    // Circular index wrap; the sum never reaches 2*DEPTH because at most
    // 16 slots (<= DEPTH) are added to a pointer below DEPTH.
    function automatic logic [c_PW-1:0] f_wrap(input logic [c_CW-1:0] s);
        logic [c_CW-1:0] t;
        t = (s >= c_DEPTH) ? (s - c_DEPTH) : s;
        return t[c_PW-1:0];
    endfunction

    // ---------------- control ----------------
    assign w_start_acc  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_active     = (r_state == S_GEN) || (r_state == S_PROP);
    assign w_wdt_expire = w_active && (r_wdt == c_WDT_LAST);
    assign w_prop_exit  = r_prop_seen && !w_ray_busy && !hold_in;

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_GEN;
            S_GEN:   w_state_nxt = w_wdt_expire ? S_DONE : S_PROP;
            S_PROP:  if (w_wdt_expire || w_prop_exit) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_GEN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- own piece decode ----------------
    assign w_sq_empty  = (cpiece[2:0] == c_EMPTY);
    assign w_opp       = !w_sq_empty && (cpiece[3] != side);
    assign w_emit      = !w_sq_empty && (cpiece[3] == side);
    assign w_own_tok   = {xpos, ypos, cpiece[2:0]};
    assign w_start_row = side ? c_ROW_PRE : c_ROW_ONE;
    assign w_last_rank = side ? {COORD_W{1'b0}} : c_ROW_LAST;

    always_comb begin : p_emit_mask
        w_ray_mask = 8'h00;
        w_kn_emit  = 1'b0;
        if (w_emit) begin
            case (cpiece[2:0])
                c_PAWN:          w_ray_mask = side ? 8'b1001_0100 : 8'b0010_1001;
                c_KNIGHT:        w_kn_emit  = 1'b1;
                c_BISHOP:        w_ray_mask = 8'b1010_0101;
                c_ROOK:          w_ray_mask = 8'b0101_1010;
                c_QUEEN, c_KING: w_ray_mask = 8'hFF;
                default:         w_ray_mask = 8'h00;
            endcase
        end
    end

    // ---------------- token evaluation ----------------
    always_comb begin : p_eval
        logic [TOK_W-1:0]   w_tok;
        logic [2:0]         w_ttype;
        logic [COORD_W-1:0] w_ox;
        logic [COORD_W-1:0] w_oy;
        logic [COORD_W:0]   w_ye;
        logic [COORD_W:0]   w_oye;
        logic w_vld, w_go, w_cap, w_pawn, w_pawn2, w_ep, w_prom, w_d1, w_d2;
        w_tok = '0; w_ttype = '0; w_ox = '0; w_oy = '0; w_ye = '0; w_oye = '0;
        w_vld = 1'b0; w_go = 1'b0; w_cap = 1'b0; w_pawn = 1'b0;
        w_pawn2 = 1'b0; w_ep = 1'b0; w_prom = 1'b0; w_d1 = 1'b0; w_d2 = 1'b0;
        w_fwd      = '0;
        w_cand_vld = '0;
        for (int i = 0; i < c_NCAND; i++) w_cand[i] = '0;

        for (int d = 0; d < 8; d++) begin
            w_tok   = ray_in[d*TOK_W +: TOK_W];
            w_ttype = w_tok[2:0];
            w_ox    = w_tok[TOK_W-1 -: COORD_W];
            w_oy    = w_tok[2+COORD_W -: COORD_W];
            w_ye    = {1'b0, ypos};
            w_oye   = {1'b0, w_oy};
            // Row distance computed one bit wider so edge rows never alias.
            w_d1    = (w_ye == w_oye + c_X1) || (w_oye == w_ye + c_X1);
            w_d2    = (w_ye == w_oye + c_X2) || (w_oye == w_ye + c_X2);
            w_vld = 1'b0; w_go = 1'b0; w_cap = 1'b0;
            w_pawn = 1'b0; w_pawn2 = 1'b0; w_ep = 1'b0;
            case (w_ttype)
                c_BISHOP, c_ROOK, c_QUEEN: begin
                    if (w_sq_empty) begin
                        w_vld = 1'b1;
                        w_go  = 1'b1;
                    end else if (w_opp) begin
                        w_vld = 1'b1;
                        w_cap = 1'b1;
                    end
                end
                c_KING: begin
                    w_vld = w_sq_empty || w_opp;
                    w_cap = w_opp;
                end
                c_PAWN: begin
                    if (d == 3 || d == 4) begin
                        if (w_sq_empty) begin
                            w_vld   = 1'b1;
                            w_pawn  = 1'b1;
                            w_pawn2 = w_d2;
                            // Only a first step off the start row may continue.
                            w_go    = (w_oy == w_start_row) && w_d1;
                        end
                    end else if (w_opp) begin
                        w_vld  = 1'b1;
                        w_cap  = 1'b1;
                        w_pawn = 1'b1;
                    end else if (w_sq_empty && ep_target) begin
                        w_vld  = 1'b1;
                        w_ep   = 1'b1;
                        w_cap  = 1'b1;
                        w_pawn = 1'b1;
                    end
                end
                default: w_vld = 1'b0;
            endcase
            w_vld  = w_vld && (r_state == S_PROP);
            w_prom = w_pawn && (ypos == w_last_rank);
            w_cand_vld[d] = w_vld;
            w_cand[d]     = {1'b0, w_prom, w_pawn, w_pawn2, w_ep, 1'b0, w_cap,
                             w_ox, w_oy, xpos, ypos};
            if (w_vld && w_go) w_fwd[d*TOK_W +: TOK_W] = w_tok;
        end

        // Knight tokens only arrive in the first PROP cycle.
        for (int k = 0; k < 8; k++) begin
            w_tok = knight_in[k*TOK_W +: TOK_W];
            w_ox  = w_tok[TOK_W-1 -: COORD_W];
            w_oy  = w_tok[2+COORD_W -: COORD_W];
            w_cand_vld[8+k] = (r_state == S_PROP) && !r_prop_seen &&
                              (w_tok[2:0] != c_EMPTY) && (w_sq_empty || w_opp);
            w_cand[8+k] = {6'b000000, w_opp, w_ox, w_oy, xpos, ypos};
        end
    end

    always_comb begin : p_busy
        w_ray_busy = 1'b0;
        w_hold     = 1'b0;
        for (int d = 0; d < 8; d++) begin
            w_ray_busy = w_ray_busy | (|ray_in[d*TOK_W +: 3]);
            w_hold     = w_hold | (|r_ray_out[d*TOK_W +: 3]);
        end
    end

    always_comb begin : p_ray_nxt
        w_ray_nxt = '0;
        if (r_state == S_GEN) begin
            for (int d = 0; d < 8; d++)
                w_ray_nxt[d*TOK_W +: TOK_W] = w_ray_mask[d] ? w_own_tok : '0;
        end else begin
            w_ray_nxt = w_fwd;
        end
    end

    // ---------------- FIFO allocation ----------------
    assign w_pop  = (r_count != '0) && move_ready;
    assign w_free = c_DEPTH - r_count + c_CW'(w_pop);

    always_comb begin : p_alloc
        w_nvalid = '0;
        for (int i = 0; i < c_NCAND; i++) begin
            w_slot[i]   = w_nvalid;
            w_nvalid    = w_nvalid + c_CW'(w_cand_vld[i]);
            // Candidates are packed in index order, so the ones beyond the
            // free space are always the highest-index ones.
            w_wr_en[i]  = w_cand_vld[i] && (w_slot[i] < w_free);
            w_wr_idx[i] = f_wrap(c_CW'(r_wr_ptr) + w_slot[i]);
        end
        w_drop = (w_nvalid > w_free);
        w_nwr  = w_drop ? w_free : w_nvalid;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ray_out   <= '0;
            r_kn_out    <= '0;
            r_overflow  <= 1'b0;
            r_prop_seen <= 1'b0;
            r_wdt       <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ray_out   <= w_ray_nxt;
            r_kn_out    <= (r_state == S_GEN && w_kn_emit) ? {8{w_own_tok}} : '0;
            r_prop_seen <= (r_state == S_PROP);
            if (w_start_acc) begin
                r_wdt      <= '0;
                r_overflow <= 1'b0;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_active) r_wdt <= r_wdt + c_WW'(1);
                if (w_drop)   r_overflow <= 1'b1;
                r_count  <= r_count - c_CW'(w_pop) + w_nwr;
                r_wr_ptr <= f_wrap(c_CW'(r_wr_ptr) + w_nwr);
                if (w_pop) r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NCAND; i++)
            if (w_wr_en[i]) r_mem[w_wr_idx[i]] <= w_cand[i];
    end

    assign ray_out    = r_ray_out;
    assign knight_out = r_kn_out;
    assign hold_out   = w_hold;
    assign move_data  = r_mem[r_rd_ptr];
    assign move_valid = (r_count != '0);
    assign done       = (r_state == S_DONE);
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_square_unit_v2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_square_unit_v2                                             |
// | Purpose  : Directed self-checking bench for square_unit_v2: a default    |
// |            instance (DEPTH 32) and a DEPTH 16 instance for overflow.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_square_unit_v2;

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_fail   = 0;

    // instance A (DEPTH 32)
    logic        start, side, ep_target, hold_in, move_ready;
    logic [2:0]  xpos, ypos;
    logic [3:0]  cpiece;
    logic [71:0] ray_in, knight_in;
    logic [71:0] ray_out, knight_out;
    logic        hold_out, move_valid, done, overflow;
    logic [18:0] move_data;

    // instance B (DEPTH 16)
    logic        start_b, side_b, ep_target_b, hold_in_b, move_ready_b;
    logic [2:0]  xpos_b, ypos_b;
    logic [3:0]  cpiece_b;
    logic [71:0] ray_in_b, knight_in_b;
    logic [71:0] ray_out_b, knight_out_b;
    logic        hold_out_b, move_valid_b, done_b, overflow_b;
    logic [18:0] move_data_b;

    logic [71:0] exp_v;
    logic [18:0] exp_q [16];
    int          n;

    always #5 clk = ~clk;

    square_unit_v2 #(.COORD_W(3), .DEPTH(32), .WDT_CYCLES(15)) dut (
        .clk(clk), .reset(reset), .start(start), .xpos(xpos), .ypos(ypos),
        .cpiece(cpiece), .side(side), .ep_target(ep_target), .ray_in(ray_in),
        .knight_in(knight_in), .hold_in(hold_in), .ray_out(ray_out),
        .knight_out(knight_out), .hold_out(hold_out), .move_data(move_data),
        .move_valid(move_valid), .move_ready(move_ready), .done(done),
        .overflow(overflow)
    );

    square_unit_v2 #(.COORD_W(3), .DEPTH(16), .WDT_CYCLES(15)) dut16 (
        .clk(clk), .reset(reset), .start(start_b), .xpos(xpos_b), .ypos(ypos_b),
        .cpiece(cpiece_b), .side(side_b), .ep_target(ep_target_b), .ray_in(ray_in_b),
        .knight_in(knight_in_b), .hold_in(hold_in_b), .ray_out(ray_out_b),
        .knight_out(knight_out_b), .hold_out(hold_out_b), .move_data(move_data_b),
        .move_valid(move_valid_b), .move_ready(move_ready_b), .done(done_b),
        .overflow(overflow_b)
    );

    function automatic logic [8:0] tok(input logic [2:0] x, input logic [2:0] y,
                                       input logic [2:0] t);
        return {x, y, t};
    endfunction

    function automatic logic [18:0] mv(input logic [6:0] f, input logic [2:0] fx,
                                       input logic [2:0] fy, input logic [2:0] tx,
                                       input logic [2:0] ty);
        return {f, fx, fy, tx, ty};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse on A; returns in the first PROP cycle (GEN tokens visible).
    task automatic gen_a();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // Evaluate one ray token on A for one PROP cycle, leave in PROP2.
    task automatic ray_a(input int d, input logic [8:0] t);
        gen_a();
        ray_in[d*9 +: 9] = t;
        tick();
        ray_in = '0;
    endtask

    task automatic pop_a();
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 0; side = 0; ep_target = 0; hold_in = 0; move_ready = 0;
        xpos = 0; ypos = 0; cpiece = 0; ray_in = '0; knight_in = '0;
        start_b = 0; side_b = 0; ep_target_b = 0; hold_in_b = 0; move_ready_b = 0;
        xpos_b = 0; ypos_b = 0; cpiece_b = 0; ray_in_b = '0; knight_in_b = '0;
        tick();
        tick();
        chk("rst_ray_out", ray_out, 72'd0);
        chk("rst_kn_out", knight_out, 72'd0);
        chk("rst_hold", hold_out, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_valid", move_valid, 0);
        reset = 1'b0;
        tick();

        // White rook at (0,0): tokens on 1,3,4,6, done after two PROP cycles.
        cpiece = 4'b0100; xpos = 0; ypos = 0; side = 0;
        gen_a();
        exp_v = '0;
        exp_v[1*9 +: 9] = tok(0, 0, 4);
        exp_v[3*9 +: 9] = tok(0, 0, 4);
        exp_v[4*9 +: 9] = tok(0, 0, 4);
        exp_v[6*9 +: 9] = tok(0, 0, 4);
        chk("rook_ray_out", ray_out, exp_v);
        chk("rook_hold", hold_out, 1);
        chk("rook_kn_out", knight_out, 72'd0);
        chk("rook_done_p1", done, 0);
        tick();
        chk("rook_done_p2", done, 0);
        chk("rook_ray_clr", ray_out, 72'd0);
        tick();
        chk("rook_done", done, 1);
        chk("rook_nomove", move_valid, 0);

        // White pawn single push from start row onto empty (3,2): forwarded.
        cpiece = 4'b0000; xpos = 3; ypos = 2;
        ray_a(3, tok(3, 1, 1));
        chk("push1_valid", move_valid, 1);
        chk("push1_move", move_data, mv(7'b0010000, 3, 1, 3, 2));
        exp_v = '0;
        exp_v[3*9 +: 9] = tok(3, 1, 1);
        chk("push1_fwd", ray_out, exp_v);
        tick();
        chk("push1_done", done, 1);
        chk("push1_ray_clr", ray_out, 72'd0);
        pop_a();
        chk("push1_drained", move_valid, 0);

        // Double push lands on (3,3): pawn2, not forwarded.
        ypos = 3;
        ray_a(3, tok(3, 1, 1));
        chk("push2_move", move_data, mv(7'b0011000, 3, 1, 3, 3));
        chk("push2_nofwd", ray_out, 72'd0);
        tick();
        pop_a();

        // White bishop hits black piece on (4,4): capture, stops.
        cpiece = 4'b1001; xpos = 4; ypos = 4;
        ray_a(0, tok(6, 2, 3));
        chk("cap_move", move_data, mv(7'b0000001, 6, 2, 4, 4));
        chk("cap_nofwd", ray_out, 72'd0);
        tick();
        pop_a();
        chk("cap_one_move", move_valid, 0);

        // En-passant diagonal onto empty (5,5).
        cpiece = 4'b0000; xpos = 5; ypos = 5; ep_target = 1;
        ray_a(5, tok(4, 4, 1));
        chk("ep_move", move_data, mv(7'b0010101, 4, 4, 5, 5));
        tick();
        pop_a();
        ep_target = 0;

        // Own white knight on (2,5): knight tokens emitted, own queen blocked.
        cpiece = 4'b0010; xpos = 2; ypos = 5;
        gen_a();
        chk("kn_emit", knight_out, {8{tok(2, 5, 2)}});
        chk("kn_no_ray", ray_out, 72'd0);
        ray_in[6*9 +: 9] = tok(0, 5, 5);
        tick();
        ray_in = '0;
        chk("own_block", move_valid, 0);
        chk("own_nofwd", ray_out, 72'd0);
        tick();

        // Black pawn promotes on (2,0).
        side = 1; cpiece = 4'b0000; xpos = 2; ypos = 0;
        ray_a(4, tok(2, 1, 1));
        chk("promo_move", move_data, mv(7'b0110000, 2, 1, 2, 0));
        chk("promo_nofwd", ray_out, 72'd0);
        tick();
        pop_a();
        side = 0;

        // Knight capture of black rook on (1,1); knight input ignored in PROP2.
        cpiece = 4'b1100; xpos = 1; ypos = 1;
        gen_a();
        knight_in[3*9 +: 9] = tok(2, 3, 2);
        tick();
        chk("kn_move", move_data, mv(7'b0000001, 2, 3, 1, 1));
        tick();
        knight_in = '0;
        pop_a();
        chk("kn_first_only", move_valid, 0);

        // Watchdog: hold_in high, a start inside PROP must be ignored.
        cpiece = 4'b0000; hold_in = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            start = (n == 4);
            tick();
            n++;
        end
        start = 1'b0;
        chk("wdt_cycles", n, 15);
        hold_in = 0;

        // DEPTH 16: 16 candidates fill exactly, then 8 more with one pop.
        cpiece_b = 4'b0000; xpos_b = 4; ypos_b = 4;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        for (int d = 0; d < 8; d++) begin
            ray_in_b[d*9 +: 9]    = tok(3'(d), 1, 3);
            knight_in_b[d*9 +: 9] = tok(3'(d), 2, 2);
        end
        tick();
        chk("full16_ovf", overflow_b, 0);
        chk("full16_head", move_data_b, mv(7'b0000000, 0, 1, 4, 4));
        move_ready_b = 1'b1;
        tick();
        move_ready_b = 1'b0;
        ray_in_b = '0;
        knight_in_b = '0;
        chk("drop_ovf", overflow_b, 1);
        for (int i = 0; i < 7; i++) exp_q[i] = mv(7'b0000000, 3'(i + 1), 1, 4, 4);
        for (int k = 0; k < 8; k++) exp_q[7 + k] = mv(7'b0000000, 3'(k), 2, 4, 4);
        exp_q[15] = mv(7'b0000000, 0, 1, 4, 4);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), move_data_b, exp_q[i]);
            move_ready_b = 1'b1;
            tick();
            move_ready_b = 1'b0;
        end
        chk("drain_empty", move_valid_b, 0);
        chk("drain_done", done_b, 1);
        chk("ovf_sticky", overflow_b, 1);
        chk("b_idle_out", {hold_out_b, knight_out_b, ray_out_b}, 73'd0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("ovf_cleared", overflow_b, 0);
        tick();
        tick();
        tick();

        // Reset in PROP aborts and discards the queue.
        cpiece = 4'b0000; xpos = 3; ypos = 2;
        ray_a(3, tok(3, 1, 1));
        chk("pre_rst_valid", move_valid, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", move_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ray", ray_out, 72'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
